sram_bus_arbiter: RTL

//  Shares one SRAM-like bus port between the CPU's instruction-fetch master and its data-access master.

---
 rtl/sram_bus_pkg.sv | 14 +
 rtl/id_fifo.sv | 43 ++++
 rtl/sram_bus_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM-like bus arbiter: master IDs, size encodings,
// and the grant FSM state type.
package sram_bus_pkg;

   localparam logic ID_INST = 1'b0;
   localparam logic ID_DATA = 1'b1;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic {IDLE, HOLD} grant_state_e;

endpackage

// File: rtl/id_fifo.sv
// Small synchronous FIFO of 1-bit master IDs for requests still awaiting a response.
// Read/write pointers carry one extra wrap bit so that full and empty can be told apart.
module id_fifo #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]   wr_ptr_q;
   logic [AW:0]   rd_ptr_q;
   logic [AW:0]   count;
   logic          mem_q [2**AW];

   assign count = wr_ptr_q - rd_ptr_q;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus port between the instruction-fetch and data masters.
// Data has priority; inst is forced one grant after STARVE_LIMIT consecutive data grants.
module sram_bus_arbiter
   import sram_bus_pkg::*;
#(
   parameter int unsigned OUTS_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   output logic        err_orphan
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   grant_state_e state_q, state_d;
   logic         owner_q, owner_d;
   logic         owner;
   logic         grant;
   logic         handshake;
   logic         resp;
   logic [SW-1:0] starve_q, starve_d;
   logic         err_orphan_q;
   logic         fifo_full, fifo_empty, fifo_dout;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= ID_INST;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      unique case (state_q)
         IDLE: begin
            if (grant && !bus_addr_ok) begin
               state_d = HOLD;
               owner_d = owner;
            end
         end
         HOLD: begin
            if (bus_addr_ok) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A held request stays on the bus unchanged until accepted, whatever the other master does.
   always_comb begin
      grant = 1'b0;
      owner = owner_q;
      unique case (state_q)
         IDLE: begin
            grant = !fifo_full && (inst_req || data_req);
            owner = (data_req && !(inst_req && (starve_q == SW'(STARVE_LIMIT)))) ?
                    ID_DATA : ID_INST;
         end
         HOLD: grant = 1'b1;
         default: grant = 1'b0;
      endcase
      if (reset) begin
         grant = 1'b0;
      end
   end

   assign bus_req   = grant;
   assign bus_wr    = (owner == ID_DATA) ? data_wr    : inst_wr;
   assign bus_size  = (owner == ID_DATA) ? data_size  : inst_size;
   assign bus_wstrb = (owner == ID_DATA) ? data_wstrb : inst_wstrb;
   assign bus_addr  = (owner == ID_DATA) ? data_addr  : inst_addr;
   assign bus_wdata = (owner == ID_DATA) ? data_wdata : inst_wdata;

   assign handshake    = grant && bus_addr_ok;
   assign inst_addr_ok = handshake && (owner == ID_INST);
   assign data_addr_ok = handshake && (owner == ID_DATA);

   assign resp         = bus_data_ok && !fifo_empty && !reset;
   assign inst_data_ok = resp && (fifo_dout == ID_INST);
   assign data_data_ok = resp && (fifo_dout == ID_DATA);
   assign inst_rdata   = bus_rdata;
   assign data_rdata   = bus_rdata;
   assign err_orphan   = err_orphan_q;

   id_fifo #(
      .DEPTH (OUTS_DEPTH)
   ) u_id_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (handshake),
      .pop   (resp),
      .din   (owner),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      starve_d = starve_q;
      if (!inst_req || (handshake && (owner == ID_INST))) begin
         starve_d = '0;
      end else if (handshake && (starve_q != SW'(STARVE_LIMIT))) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q     <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         starve_q <= starve_d;
         if (bus_data_ok && fifo_empty) begin
            err_orphan_q <= 1'b1;
         end
      end
   end

endmodule
